nv_ram_rwsp_32x129_fifo_ctrl: RTL

Flow-controlled FIFO controller that owns one 32-entry × 129-bit two-port RAM with a registered read address and a gated output register (instantiated beside it as `nv_ram_rwsp_32x129`). It turns the RAM's raw write and read ports into a valid/ready push interface and a valid/ready pop interface. It manages the write and read pointers and the occupancy count, and stalls the RAM's 2-stage read pipeline using `re`/`ore` so throughput stays at one word per cycle. It sits between a 129-bit producer and consumer in the core clock domain.

---
 rtl/nv_ram_rwsp_32x129_fifo_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/nv_ram_rwsp_32x129_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// nv_ram_rwsp_32x129_fifo_ctrl
//
// Purpose:
//   Flow-controlled FIFO controller wrapped around one 32 x 129 two-port RAM
//   (nv_ram_rwsp_32x129). The RAM has a registered read address (loaded by
//   ram_re) and a gated output register (loaded by ram_ore). This block turns
//   those raw ports into a valid/ready push side and a valid/ready pop side.
//   It tracks write/read pointers and occupancy, and advances or holds the
//   RAM's two read stages so that one word per cycle can be sustained.
//
// Ports:
//   clk        core clock (single domain)
//   rst        synchronous active-high reset
//   wr_pvld    producer word valid
//   wr_prdy    controller accepts the word (depends on state only)
//   wr_pd      producer payload
//   rd_pvld    consumer word valid
//   rd_prdy    consumer accepts the word
//   rd_pd      consumer payload, taken straight from ram_dout
//   ram_we     RAM write enable
//   ram_wa     RAM write address
//   ram_di     RAM write data
//   ram_re     RAM read-address register load
//   ram_ra     RAM read address
//   ram_ore    RAM output-register load
//   ram_dout   RAM registered read data
//   fifo_count occupancy, 0..DEPTH (includes words inside the read stages)
// -----------------------------------------------------------------------------
module nv_ram_rwsp_32x129_fifo_ctrl #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 129,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic             ram_we,
  output logic [AW-1:0]    ram_wa,
  output logic [WIDTH-1:0] ram_di,
  output logic             ram_re,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [AW:0]      fifo_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_CNT = {(AW+1){1'b0}};

  // Architectural state
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW:0]   count_q,    count_d;
  logic [AW:0]   unissued_q, unissued_d;
  logic          s1_vld_q,   s1_vld_d;   // mirrors RAM read-address register
  logic          s2_vld_q,   s2_vld_d;   // mirrors RAM output register

  // Handshake / pipeline control
  logic push_s;
  logic pop_s;
  logic s1_adv_s;
  logic issue_s;

  // Full is judged on registered count only, so a same-cycle pop never
  // opens the write side; the freed slot shows up one cycle later.
  assign wr_prdy = !rst && (count_q != FULL_CNT);
  assign push_s  = wr_pvld && wr_prdy;

  assign rd_pvld = !rst && s2_vld_q;
  assign pop_s   = rd_pvld && rd_prdy;

  // Stage 1 moves into the output register when stage 2 is free or leaving.
  assign s1_adv_s = !rst && s1_vld_q && (!s2_vld_q || pop_s);

  // A new address is loaded only for words written on an earlier cycle
  // (unissued is registered), and only when stage 1 is empty or advancing.
  assign issue_s  = !rst && (unissued_q != ZERO_CNT) && (!s1_vld_q || s1_adv_s);

  // RAM port wiring
  assign ram_we  = push_s;
  assign ram_wa  = wr_ptr_q;
  assign ram_di  = wr_pd;
  assign ram_re  = issue_s;
  assign ram_ra  = rd_ptr_q;
  assign ram_ore = s1_adv_s;
  assign rd_pd   = ram_dout;

  assign fifo_count = count_q;

  // Next-state computation for pointers, counters and stage valids
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    unissued_d = unissued_q;
    s1_vld_d   = s1_vld_q;
    s2_vld_d   = s2_vld_q;

    // Pointers wrap naturally at 2**AW == DEPTH.
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (issue_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // count releases a slot only at the consumer pop, so the entries held in
    // either read stage can never be overwritten by the producer.
    count_d    = count_q    + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    unissued_d = unissued_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, issue_s};

    if (issue_s) begin
      s1_vld_d = 1'b1;
    end else begin
      s1_vld_d = s1_vld_q && !s1_adv_s;
    end

    if (s1_adv_s) begin
      s2_vld_d = 1'b1;
    end else begin
      s2_vld_d = s2_vld_q && !pop_s;
    end
  end

  // State registers with synchronous reset; RAM contents are not touched
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= ZERO_CNT;
      unissued_q <= ZERO_CNT;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      unissued_q <= unissued_d;
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
    end
  end

endmodule
